// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and loader state encoding
package riscv_mem_pkg;

   localparam int DEF_MEM_BYTES = 16384;
   localparam int HDR_LEN       = 2;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR0,
      LD_HDR1,
      LD_DATA,
      LD_WRITE,
      LD_CSUM,
      LD_DONE,
      LD_ERR
   } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory port out
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_en;
   logic                  rd_wr;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [31:0]           write_data;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, mem_en, rd_wr, write_addr, write_data
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, mem_en, rd_wr, write_addr, write_data
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs four stream bytes into a little-endian word
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        last_lane,
   output logic        word_ready
);
   logic [1:0] lane;

   // Shifting right puts the first byte of the word in bits 7:0 after four lanes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane       <= 2'd0;
         word       <= 32'd0;
         word_ready <= 1'b0;
      end else if (clear) begin
         lane       <= 2'd0;
         word       <= 32'd0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= byte_en && (lane == 2'd3);
         if (byte_en) begin
            word <= {byte_data, word[31:8]};
            lane <= lane + 2'd1;
         end
      end
   end

   assign last_lane = (lane == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed boot-image writer for the instruction memory
module imem_loader
   import riscv_mem_pkg::*;
#(
   parameter int MEM_BYTES  = DEF_MEM_BYTES,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_base,
   imem_loader_if.master         bus,
   output logic                  cpu_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   ld_state_t             state, state_nx;
   logic [ADDR_WIDTH-1:0] base_q, addr_q;
   logic [7:0]            cnt_lo_q, csum_q;
   logic [15:0]           count_q, idx_q, idx_inc, count_hdr;
   logic [ADDR_WIDTH+1:0] end_addr;
   logic                  byte_ready, accept, start_ok;
   logic                  mem_en, rd_wr;
   logic [31:0]           asm_word;
   logic                  asm_last_lane, asm_word_ready;

   assign byte_ready = state inside {LD_HDR0, LD_HDR1, LD_DATA, LD_CSUM};
   assign accept     = bus.byte_valid && byte_ready;
   assign start_ok   = load_start && (state inside {LD_IDLE, LD_DONE, LD_ERR});
   assign idx_inc    = idx_q + 16'd1;
   assign count_hdr  = {bus.byte_data, cnt_lo_q};
   // Two extra bits so a base near the top of the address space cannot wrap past the check.
   assign end_addr   = {2'b00, base_q} + {{(ADDR_WIDTH-16){1'b0}}, count_hdr, 2'b00};

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_en    (accept && (state == LD_DATA)),
      .byte_data  (bus.byte_data),
      .word       (asm_word),
      .last_lane  (asm_last_lane),
      .word_ready (asm_word_ready)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= LD_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mem_en    = 1'b0;
      rd_wr     = 1'b0;
      cpu_rst_n = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         LD_IDLE, LD_DONE, LD_ERR: begin
            mem_en    = 1'b1;
            rd_wr     = 1'b1;
            cpu_rst_n = (state == LD_DONE);
            done      = (state == LD_DONE);
            error     = (state == LD_ERR);
            if (load_start)
               state_nx = (load_base[1:0] != 2'b00) ? LD_ERR : LD_HDR0;
         end
         LD_HDR0: begin
            busy = 1'b1;
            if (accept) state_nx = LD_HDR1;
         end
         LD_HDR1: begin
            busy = 1'b1;
            if (accept) begin
               if (end_addr > (ADDR_WIDTH+2)'(MEM_BYTES)) state_nx = LD_ERR;
               else if (count_hdr == 16'd0)               state_nx = LD_CSUM;
               else                                       state_nx = LD_DATA;
            end
         end
         LD_DATA: begin
            busy = 1'b1;
            if (accept && asm_last_lane) state_nx = LD_WRITE;
         end
         LD_WRITE: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            state_nx = (idx_inc == count_q) ? LD_CSUM : LD_DATA;
         end
         LD_CSUM: begin
            busy = 1'b1;
            if (accept) state_nx = (bus.byte_data == csum_q) ? LD_DONE : LD_ERR;
         end
         default: state_nx = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q   <= '0;
         addr_q   <= '0;
         cnt_lo_q <= 8'd0;
         csum_q   <= 8'd0;
         count_q  <= 16'd0;
         idx_q    <= 16'd0;
      end else if (start_ok) begin
         base_q  <= load_base;
         addr_q  <= load_base;
         csum_q  <= 8'd0;
         count_q <= 16'd0;
         idx_q   <= 16'd0;
      end else begin
         if (accept && (state != LD_CSUM)) csum_q   <= csum_q ^ bus.byte_data;
         if (accept && (state == LD_HDR0)) cnt_lo_q <= bus.byte_data;
         if (accept && (state == LD_HDR1)) count_q  <= count_hdr;
         // Address advances only after the WRITE cycle, so it is stable while the word is written.
         if (asm_word_ready) begin
            idx_q  <= idx_inc;
            addr_q <= addr_q + ADDR_WIDTH'(4);
         end
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.mem_en     = mem_en;
   assign bus.rd_wr      = rd_wr;
   assign bus.write_addr = addr_q;
   assign bus.write_data = asm_word;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;
   import riscv_mem_pkg::*;

   typedef struct {
      logic [31:0]      base;
      int               nbytes;
      logic [0:15][7:0] bytes;
      bit               gap;
      bit               exp_done;
      bit               exp_err;
      int               exp_writes;
      logic [31:0]      a0, d0, a1, d1;
   } vec_t;

   localparam logic [0:15][7:0] NOM  = 128'h0200130510009305_2000B200_00000000;
   localparam logic [0:15][7:0] BAD  = 128'h0200130510009305_2000B300_00000000;
   localparam logic [0:15][7:0] HDR2 = 128'h02000000_00000000_00000000_00000000;
   localparam logic [0:15][7:0] ONE  = 128'h0100EFBE_ADDE2300_00000000_00000000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0;
   logic [31:0] load_base = 32'd0;
   logic        cpu_rst_n, busy, done, error;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   vec_t        vecs[7];

   imem_loader_if #(.ADDR_WIDTH(32)) ifc ();

   imem_loader #(.MEM_BYTES(DEF_MEM_BYTES), .ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_base  (load_base),
      .bus        (ifc.master),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Memory-side observer: every write strobe is logged and must coincide with byte_ready low.
   always @(negedge clk) begin
      if (rst && ifc.mem_en && !ifc.rd_wr) begin
         wq_addr.push_back(ifc.write_addr);
         wq_data.push_back(ifc.write_data);
         check("byte_ready_in_write", 32'(ifc.byte_ready), 32'd0);
      end
   end

   task automatic start_load(input logic [31:0] b);
      load_base  = b;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit r;
      int n;
      n = 0;
      ifc.byte_valid = 1'b1;
      ifc.byte_data  = b;
      do begin
         @(negedge clk);
         r = ifc.byte_ready;
         @(posedge clk); #1;
         n++;
      end while (!r && n < 20);
      if (!r) check("byte_accept_timeout", 32'(r), 32'd1);
      if (gap) begin
         ifc.byte_valid = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      wq_addr.delete();
      wq_data.delete();
      start_load(v.base);
      check($sformatf("v%0d_start_flags", k), 32'({done, error, busy}), 32'b001);
      for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[i], v.gap);
      ifc.byte_valid = 1'b0;
      check($sformatf("v%0d_status", k), 32'({done, error, cpu_rst_n, ifc.rd_wr, busy}),
            32'({v.exp_done, v.exp_err, v.exp_done, 1'b1, 1'b0}));
      check($sformatf("v%0d_nwrites", k), 32'(wq_addr.size()), 32'(v.exp_writes));
      if (v.exp_writes >= 1 && wq_addr.size() >= 1) begin
         check($sformatf("v%0d_addr0", k), wq_addr[0], v.a0);
         check($sformatf("v%0d_data0", k), wq_data[0], v.d0);
      end
      if (v.exp_writes >= 2 && wq_addr.size() >= 2) begin
         check($sformatf("v%0d_addr1", k), wq_addr[1], v.a1);
         check($sformatf("v%0d_data1", k), wq_data[1], v.d1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          base        n   bytes gap done err nw  a0        d0            a1        d1
      vecs[0] = '{32'h0000,  11, NOM,  0,  1,   0,  2,  32'h0,    32'h00100513, 32'h4,    32'h00200593};
      vecs[1] = '{32'h0000,  11, BAD,  0,  0,   1,  2,  32'h0,    32'h00100513, 32'h4,    32'h00200593};
      vecs[2] = '{32'h3FFC,  2,  HDR2, 0,  0,   1,  0,  32'h0,    32'h0,        32'h0,    32'h0};
      vecs[3] = '{32'h0000,  3,  '0,   0,  1,   0,  0,  32'h0,    32'h0,        32'h0,    32'h0};
      vecs[4] = '{32'h0000,  11, NOM,  1,  1,   0,  2,  32'h0,    32'h00100513, 32'h4,    32'h00200593};
      vecs[5] = '{32'h3FF8,  11, NOM,  0,  1,   0,  2,  32'h3FF8, 32'h00100513, 32'h3FFC, 32'h00200593};
      vecs[6] = '{32'h0040,  7,  ONE,  0,  1,   0,  1,  32'h40,   32'hDEADBEEF, 32'h0,    32'h0};

      ifc.byte_valid = 1'b0;
      ifc.byte_data  = 8'd0;
      #12;
      check("reset_flags", 32'({ifc.byte_ready, ifc.mem_en, ifc.rd_wr, cpu_rst_n, busy, done, error}),
            32'b0110000);
      check("reset_write_addr", ifc.write_addr, 32'd0);
      check("reset_write_data", ifc.write_data, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

      // Misaligned base goes straight to ERR on the edge that takes load_start.
      wq_addr.delete();
      start_load(32'h2);
      check("misalign_flags", 32'({done, error, busy, ifc.rd_wr}), 32'b0101);
      @(posedge clk); #1;
      check("misalign_nwrites", 32'(wq_addr.size()), 32'd0);

      // Reset lands in the WRITE cycle of the first word; that write must never reach memory.
      wq_addr.delete();
      start_load(32'h0);
      for (int i = 0; i < 6; i++) send_byte(NOM[i], 1'b0);
      ifc.byte_valid = 1'b0;
      check("pre_reset_in_write", 32'({ifc.mem_en, ifc.rd_wr, ifc.byte_ready, busy}), 32'b1001);
      rst = 1'b0;
      #1;
      check("midreset_flags", 32'({ifc.byte_ready, ifc.mem_en, ifc.rd_wr, cpu_rst_n, busy, done, error}),
            32'b0110000);
      check("midreset_write_addr", ifc.write_addr, 32'd0);
      check("midreset_write_data", ifc.write_data, 32'd0);
      @(negedge clk);
      check("midreset_nwrites", 32'(wq_addr.size()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_vec(vecs[0], 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
